// File: rtl/vadd_seq_pkg.sv
// rtl/vadd_seq_pkg.sv - shared states, ap_ctrl bit indices and response codes for the vadd sequencer
package vadd_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        WR_B,
        WR_GO,
        POLL,
        RD_C,
        RESP
    } seq_state_e;

    localparam int AP_START = 0;
    localparam int AP_DONE  = 1;

    localparam logic [1:0] RESP_OK      = 2'd0;
    localparam logic [1:0] RESP_AXIERR  = 2'd1;
    localparam logic [1:0] RESP_TIMEOUT = 2'd2;

endpackage

// File: rtl/axil_wr_chan.sv
// rtl/axil_wr_chan.sv - single AXI4-Lite write (AW+W+B) with independent AW and W completion
module axil_wr_chan #(
    parameter int DW = 32,
    parameter int AW = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   data,
    output logic            active,
    output logic            done,
    output logic            err,
    output logic [AW-1:0]   m_awaddr,
    output logic            m_awvalid,
    input  logic            m_awready,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_wstrb,
    output logic            m_wvalid,
    input  logic            m_wready,
    input  logic [1:0]      m_bresp,
    input  logic            m_bvalid,
    output logic            m_bready
);

    assign m_wstrb = '1;
    assign done    = m_bvalid & m_bready;
    assign err     = done & (m_bresp != 2'b00);
    assign active  = m_awvalid | m_wvalid | m_bready;

    // bready stays up from issue until the response arrives, so B can never be missed
    always_ff @(posedge clk) begin
        if (reset) begin
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
            m_awaddr  <= '0;
            m_wdata   <= '0;
        end else if (start) begin
            m_awvalid <= 1'b1;
            m_wvalid  <= 1'b1;
            m_bready  <= 1'b1;
            m_awaddr  <= addr;
            m_wdata   <= data;
        end else begin
            if (m_awready) m_awvalid <= 1'b0;
            if (m_wready)  m_wvalid  <= 1'b0;
            if (m_bvalid)  m_bready  <= 1'b0;
        end
    end

endmodule

// File: rtl/vadd_axil_sequencer.sv
// rtl/vadd_axil_sequencer.sv - AXI4-Lite master running one vadd add per command (A, B, start, poll, read C)
module vadd_axil_sequencer
    import vadd_seq_pkg::*;
#(
    parameter int             DW       = 32,
    parameter int             AW       = 6,
    parameter logic [AW-1:0]  CTRL_OFF = 6'h00,
    parameter logic [AW-1:0]  A_OFF    = 6'h10,
    parameter logic [AW-1:0]  B_OFF    = 6'h18,
    parameter logic [AW-1:0]  C_OFF    = 6'h20,
    parameter int             POLL_MAX = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [DW-1:0]   cmd_a,
    input  logic [DW-1:0]   cmd_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_sum,
    output logic [1:0]      rsp_err,
    output logic            busy,
    output logic [15:0]     done_cnt,
    output logic [AW-1:0]   m_awaddr,
    output logic            m_awvalid,
    input  logic            m_awready,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_wstrb,
    output logic            m_wvalid,
    input  logic            m_wready,
    input  logic [1:0]      m_bresp,
    input  logic            m_bvalid,
    output logic            m_bready,
    output logic [AW-1:0]   m_araddr,
    output logic            m_arvalid,
    input  logic            m_arready,
    input  logic [DW-1:0]   m_rdata,
    input  logic [1:0]      m_rresp,
    input  logic            m_rvalid,
    output logic            m_rready
);

    seq_state_e    state_q, state_d;
    logic [DW-1:0] a_q, b_q;
    logic [15:0]   poll_cnt, poll_next;
    logic          wr_start, wr_active, wr_done, wr_err;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          ar_issue;
    logic [AW-1:0] ar_addr_d;
    logic          rsp_load;
    logic [DW-1:0] rsp_sum_d;
    logic [1:0]    rsp_err_d;
    logic          r_hs;

    assign r_hs      = m_rvalid & m_rready;
    assign poll_next = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;

    axil_wr_chan #(.DW(DW), .AW(AW)) u_wr (
        .clk       (clk),
        .reset     (reset),
        .start     (wr_start),
        .addr      (wr_addr),
        .data      (wr_data),
        .active    (wr_active),
        .done      (wr_done),
        .err       (wr_err),
        .m_awaddr  (m_awaddr),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        rsp_valid = 1'b0;
        m_rready  = 1'b0;
        wr_start  = 1'b0;
        wr_addr   = A_OFF;
        wr_data   = a_q;
        ar_issue  = 1'b0;
        ar_addr_d = CTRL_OFF;
        rsp_load  = 1'b0;
        rsp_sum_d = '0;
        rsp_err_d = RESP_OK;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_d = WR_A;
            end
            WR_A, WR_B, WR_GO: begin
                // the channel is idle only in the first cycle of each write state
                wr_start = ~wr_active;
                if (state_q == WR_B) begin
                    wr_addr = B_OFF;
                    wr_data = b_q;
                end else if (state_q == WR_GO) begin
                    wr_addr           = CTRL_OFF;
                    wr_data           = '0;
                    wr_data[AP_START] = 1'b1;
                end
                if (wr_err) begin
                    state_d   = RESP;
                    rsp_load  = 1'b1;
                    rsp_err_d = RESP_AXIERR;
                end else if (wr_done) begin
                    case (state_q)
                        WR_A:    state_d = WR_B;
                        WR_B:    state_d = WR_GO;
                        default: begin
                            state_d  = POLL;
                            ar_issue = 1'b1;
                        end
                    endcase
                end
            end
            POLL: begin
                m_rready = 1'b1;
                if (r_hs) begin
                    if (m_rresp != 2'b00) begin
                        state_d   = RESP;
                        rsp_load  = 1'b1;
                        rsp_err_d = RESP_AXIERR;
                    end else if (m_rdata[AP_DONE]) begin
                        state_d   = RD_C;
                        ar_issue  = 1'b1;
                        ar_addr_d = C_OFF;
                    end else if (poll_next >= 16'(POLL_MAX)) begin
                        state_d   = RESP;
                        rsp_load  = 1'b1;
                        rsp_err_d = RESP_TIMEOUT;
                    end else begin
                        ar_issue = 1'b1;
                    end
                end
            end
            RD_C: begin
                m_rready = 1'b1;
                if (r_hs) begin
                    state_d  = RESP;
                    rsp_load = 1'b1;
                    if (m_rresp != 2'b00) rsp_err_d = RESP_AXIERR;
                    else                  rsp_sum_d = m_rdata;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // AR is raised on the edge that enters POLL/RD_C so the read starts in the entry cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            poll_cnt  <= '0;
            m_arvalid <= 1'b0;
            m_araddr  <= '0;
            rsp_sum   <= '0;
            rsp_err   <= RESP_OK;
            done_cnt  <= '0;
        end else begin
            if (state_q == IDLE && cmd_valid) begin
                a_q      <= cmd_a;
                b_q      <= cmd_b;
                poll_cnt <= '0;
            end
            if (state_q == POLL && r_hs) poll_cnt <= poll_next;
            if (ar_issue) begin
                m_arvalid <= 1'b1;
                m_araddr  <= ar_addr_d;
            end else if (m_arready) begin
                m_arvalid <= 1'b0;
            end
            if (rsp_load) begin
                rsp_sum <= rsp_sum_d;
                rsp_err <= rsp_err_d;
            end
            if (rsp_valid && rsp_ready && rsp_err == RESP_OK) done_cnt <= done_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_vadd_axil_sequencer.sv
// tb/tb_vadd_axil_sequencer.sv - directed bench for vadd_axil_sequencer against a behavioural vadd CTRL_BUS slave
module tb_vadd_axil_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        sel = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;

    logic        cmd_valid_v[2], cmd_ready_v[2], rsp_valid_v[2], rsp_ready_v[2], busy_v[2];
    logic [31:0] rsp_sum_v[2];
    logic [1:0]  rsp_err_v[2];
    logic [15:0] done_cnt_v[2];
    logic [5:0]  awaddr_v[2], araddr_v[2];
    logic [31:0] wdata_v[2];
    logic [3:0]  wstrb_v[2];
    logic        awvalid_v[2], awready_v[2], wvalid_v[2], wready_v[2], bvalid_v[2], bready_v[2];
    logic        arvalid_v[2], arready_v[2], rvalid_v[2], rready_v[2];

    logic [5:0]  s_awaddr, s_araddr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic        s_awready, s_wready, s_arready;
    logic        s_bvalid, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;

    // instance 0 polls up to 255 times, instance 1 gives up after 3; sel routes the slave
    for (genvar i = 0; i < 2; i++) begin : g_dut
        assign cmd_valid_v[i] = cmd_valid && (int'(sel) == i);
        assign rsp_ready_v[i] = rsp_ready && (int'(sel) == i);
        assign awready_v[i]   = s_awready && (int'(sel) == i);
        assign wready_v[i]    = s_wready && (int'(sel) == i);
        assign bvalid_v[i]    = s_bvalid && (int'(sel) == i);
        assign arready_v[i]   = s_arready && (int'(sel) == i);
        assign rvalid_v[i]    = s_rvalid && (int'(sel) == i);
        vadd_axil_sequencer #(.POLL_MAX(i == 0 ? 255 : 3)) u_dut (
            .clk(clk), .reset(reset),
            .cmd_valid(cmd_valid_v[i]), .cmd_ready(cmd_ready_v[i]),
            .cmd_a(cmd_a), .cmd_b(cmd_b),
            .rsp_valid(rsp_valid_v[i]), .rsp_ready(rsp_ready_v[i]),
            .rsp_sum(rsp_sum_v[i]), .rsp_err(rsp_err_v[i]),
            .busy(busy_v[i]), .done_cnt(done_cnt_v[i]),
            .m_awaddr(awaddr_v[i]), .m_awvalid(awvalid_v[i]), .m_awready(awready_v[i]),
            .m_wdata(wdata_v[i]), .m_wstrb(wstrb_v[i]), .m_wvalid(wvalid_v[i]), .m_wready(wready_v[i]),
            .m_bresp(s_bresp), .m_bvalid(bvalid_v[i]), .m_bready(bready_v[i]),
            .m_araddr(araddr_v[i]), .m_arvalid(arvalid_v[i]), .m_arready(arready_v[i]),
            .m_rdata(s_rdata), .m_rresp(s_rresp), .m_rvalid(rvalid_v[i]), .m_rready(rready_v[i])
        );
    end

    assign s_awaddr  = awaddr_v[sel];
    assign s_awvalid = awvalid_v[sel];
    assign s_wdata   = wdata_v[sel];
    assign s_wstrb   = wstrb_v[sel];
    assign s_wvalid  = wvalid_v[sel];
    assign s_bready  = bready_v[sel];
    assign s_araddr  = araddr_v[sel];
    assign s_arvalid = arvalid_v[sel];
    assign s_rready  = rready_v[sel];

    logic        cmd_ready_m, rsp_valid_m, busy_m;
    logic [31:0] rsp_sum_m;
    logic [1:0]  rsp_err_m;
    logic [15:0] done_cnt_m;
    assign cmd_ready_m = cmd_ready_v[sel];
    assign rsp_valid_m = rsp_valid_v[sel];
    assign busy_m      = busy_v[sel];
    assign rsp_sum_m   = rsp_sum_v[sel];
    assign rsp_err_m   = rsp_err_v[sel];
    assign done_cnt_m  = done_cnt_v[sel];

    // behavioural vadd slave: zero-wait unless aw_delay/w_delay say otherwise
    int          aw_delay = 0;
    int          w_delay = 0;
    int          done_on_poll = 1;
    logic [5:0]  err_addr = 6'h3F;
    int          aw_wait, w_wait, ctrl_reads, c_reads, go_writes;
    logic        aw_have, w_have, started;
    logic [5:0]  aw_q, last_ar, wa;
    logic [31:0] w_q, reg_a, reg_b, wd;
    logic        aw_hs, w_hs;

    assign s_awready = !aw_have && !s_bvalid && (aw_wait >= aw_delay);
    assign s_wready  = !w_have && !s_bvalid && (w_wait >= w_delay);
    assign s_arready = !s_rvalid;
    assign aw_hs     = s_awvalid && s_awready;
    assign w_hs      = s_wvalid && s_wready;
    assign wa        = aw_have ? aw_q : s_awaddr;
    assign wd        = w_have ? w_q : s_wdata;

    always @(posedge clk) begin
        if (reset) begin
            aw_have <= 0; w_have <= 0; aw_wait <= 0; w_wait <= 0; aw_q <= 0; w_q <= 0;
            s_bvalid <= 0; s_bresp <= 0; s_rvalid <= 0; s_rresp <= 0; s_rdata <= 0;
            reg_a <= 0; reg_b <= 0; started <= 0; ctrl_reads <= 0; c_reads <= 0; go_writes <= 0; last_ar <= 0;
        end else begin
            if (s_awvalid && !s_awready) aw_wait <= aw_wait + 1;
            else if (aw_hs) aw_wait <= 0;
            if (s_wvalid && !s_wready) w_wait <= w_wait + 1;
            else if (w_hs) w_wait <= 0;
            if (aw_hs) begin aw_have <= 1; aw_q <= s_awaddr; end
            if (w_hs) begin w_have <= 1; w_q <= s_wdata; end
            if ((aw_have || aw_hs) && (w_have || w_hs)) begin
                aw_have <= 0; w_have <= 0; s_bvalid <= 1;
                if (wa == err_addr) s_bresp <= 2'b10;
                else begin
                    s_bresp <= 2'b00;
                    case (wa)
                        6'h10: reg_a <= wd;
                        6'h18: reg_b <= wd;
                        6'h00: if (wd[0]) begin
                            started <= 1; ctrl_reads <= 0; c_reads <= 0; go_writes <= go_writes + 1;
                        end
                        default: ;
                    endcase
                end
            end else if (s_bvalid && s_bready) s_bvalid <= 0;
            if (s_arvalid && s_arready) begin
                s_rvalid <= 1; s_rresp <= 2'b00; last_ar <= s_araddr;
                if (s_araddr == 6'h00) begin
                    ctrl_reads <= ctrl_reads + 1;
                    s_rdata <= {30'd0, (started && done_on_poll != 0 && ctrl_reads + 1 >= done_on_poll), 1'b0};
                end else if (s_araddr == 6'h20) begin
                    c_reads <= c_reads + 1;
                    s_rdata <= reg_a + reg_b;
                end else s_rdata <= 32'd0;
            end else if (s_rvalid && s_rready) s_rvalid <= 0;
        end
    end

    // protocol watch: no valid drop or payload change before handshake, one transaction at a time
    int          viol = 0;
    logic        aw_pend, w_pend, ar_pend, mon_clr = 1'b0, aw_only_seen, w_only_seen;
    logic [5:0]  pend_awaddr, pend_araddr;
    logic [31:0] pend_wdata;
    always @(posedge clk) begin
        if (reset) begin
            aw_pend <= 0; w_pend <= 0; ar_pend <= 0;
        end else begin
            viol <= viol + int'(aw_pend && (!s_awvalid || s_awaddr != pend_awaddr))
                         + int'(w_pend && (!s_wvalid || s_wdata != pend_wdata))
                         + int'(ar_pend && (!s_arvalid || s_araddr != pend_araddr))
                         + int'(s_arvalid && s_rvalid) + int'(s_awvalid && s_bvalid)
                         + int'(w_hs && s_wstrb != 4'hF);
            aw_pend <= s_awvalid && !s_awready; pend_awaddr <= s_awaddr;
            w_pend  <= s_wvalid && !s_wready;   pend_wdata  <= s_wdata;
            ar_pend <= s_arvalid && !s_arready; pend_araddr <= s_araddr;
        end
        if (mon_clr) begin aw_only_seen <= 0; w_only_seen <= 0; end
        else begin
            if (s_awvalid && !s_wvalid) aw_only_seen <= 1;
            if (s_wvalid && !s_awvalid) w_only_seen <= 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // returns with lat = cycles after the accept edge spent waiting for rsp_valid
    task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, output int lat);
        int n;
        cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready_m && n < 20) begin @(negedge clk); n++; end
        chk("cmd_accept", cmd_ready_m, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid_m && lat < 2000) begin lat++; @(negedge clk); end
    endtask

    task automatic release_rsp;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat, g0, n;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready_m, 1);
        chk("rst_ctrl", {awvalid_v[0], wvalid_v[0], bready_v[0], arvalid_v[0], rready_v[0], rsp_valid_v[0], busy_v[0]}, 0);
        chk("rst_rsp", {rsp_sum_m, rsp_err_m, done_cnt_m}, 0);
        reset = 1'b0;

        done_on_poll = 1;
        run_cmd(32'd5, 32'd7, lat);
        chk("t1_latency", lat, 13);
        chk("t1_sum", rsp_sum_m, 32'd12);
        chk("t1_err", rsp_err_m, 0);
        chk("t1_regs", {reg_a, reg_b}, {32'd5, 32'd7});
        release_rsp();
        chk("t1_done_cnt", done_cnt_m, 1);

        aw_delay = 3; mon_clr = 1'b1; @(negedge clk); mon_clr = 1'b0;
        run_cmd(32'h1234_0000, 32'h0000_5678, lat);
        chk("t2_latency", lat, 22);
        chk("t2_sum", rsp_sum_m, 32'h1234_5678);
        chk("t2_aw_held_after_w", aw_only_seen, 1);
        chk("t2_w_never_alone", w_only_seen, 0);
        chk("t2_regs", {reg_a, reg_b}, {32'h1234_0000, 32'h0000_5678});
        release_rsp();
        chk("t2_done_cnt", done_cnt_m, 2);
        aw_delay = 0;

        done_on_poll = 4;
        run_cmd(32'd100, 32'd23, lat);
        chk("t3_latency", lat, 19);
        chk("t3_sum", rsp_sum_m, 32'd123);
        chk("t3_reads", {ctrl_reads[7:0], c_reads[7:0], 2'b00, last_ar}, {8'd4, 8'd1, 8'h20});
        release_rsp();
        chk("t3_done_cnt", done_cnt_m, 3);

        done_on_poll = 1; err_addr = 6'h18; g0 = go_writes;
        run_cmd(32'd1, 32'd2, lat);
        chk("t5_latency", lat, 6);
        chk("t5_err", rsp_err_m, 1);
        chk("t5_no_go_write", go_writes - g0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_rsp_held", {rsp_valid_m, rsp_err_m, rsp_sum_m}, {1'b1, 2'd1, 32'd0});
        end
        release_rsp();
        chk("t5_done_cnt", done_cnt_m, 3);
        err_addr = 6'h3F;

        sel = 1'b1; done_on_poll = 0;
        @(negedge clk);
        run_cmd(32'd3, 32'd4, lat);
        chk("t4_latency", lat, 15);
        chk("t4_err_sum", {rsp_err_m, rsp_sum_m}, {2'd2, 32'd0});
        chk("t4_polls", {ctrl_reads[7:0], c_reads[7:0]}, {8'd3, 8'd0});
        release_rsp();
        chk("t4_done_cnt", done_cnt_m, 0);
        sel = 1'b0;
        @(negedge clk);

        cmd_a = 32'd9; cmd_b = 32'd9; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (ctrl_reads < 2 && n < 100) begin @(negedge clk); n++; end
        chk("t6_in_poll", ctrl_reads >= 2, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_idle_after_reset", {busy_m, awvalid_v[0], wvalid_v[0], arvalid_v[0], bready_v[0], rready_v[0], rsp_valid_m, cmd_ready_m}, 8'b0000_0001);
        reset = 1'b0;
        done_on_poll = 1;
        run_cmd(32'hFFFF_FFFF, 32'd1, lat);
        chk("t6_latency", lat, 13);
        chk("t6_sum_err", {rsp_sum_m, rsp_err_m}, 0);
        release_rsp();
        chk("t6_done_cnt", done_cnt_m, 1);

        chk("axi_rules", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
